// File: rtl/param_combo_lock_if.sv
// param_combo_lock_if: digit-entry controls and lock status bundle.
//   master: drives digit_in/digit_valid/clr/lock_req/set_code, reads status.
//   slave : the lock core; reads controls, drives state/entry/entry_cnt/fail_cnt/code_set.
interface param_combo_lock_if #(
    parameter int DIGITS    = 4,
    parameter int DIGIT_W   = 4,
    parameter int MAX_TRIES = 3
);
    logic [DIGIT_W-1:0]               digit_in;
    logic                             digit_valid;
    logic                             clr;
    logic                             lock_req;
    logic                             set_code;
    logic [1:0]                       state;
    logic [DIGITS*DIGIT_W-1:0]        entry;
    logic [$clog2(DIGITS+1)-1:0]      entry_cnt;
    logic [$clog2(MAX_TRIES+1)-1:0]   fail_cnt;
    logic                             code_set;

    modport master (
        output digit_in, digit_valid, clr, lock_req, set_code,
        input  state, entry, entry_cnt, fail_cnt, code_set
    );

    modport slave (
        input  digit_in, digit_valid, clr, lock_req, set_code,
        output state, entry, entry_cnt, fail_cnt, code_set
    );
endinterface

// File: rtl/param_combo_lock.sv
// param_combo_lock: combination-lock core with failure counting, timed lockout and code reprogramming.
//   clk : rising-edge system clock.
//   rst : asynchronous, active-low reset.
//   bus : param_combo_lock_if slave (digit/control pulses in, lock status out).
module param_combo_lock #(
    parameter int                            DIGITS         = 4,
    parameter int                            DIGIT_W        = 4,
    parameter logic [DIGITS*DIGIT_W-1:0]     RESET_CODE     = '0,
    parameter int                            MAX_TRIES      = 3,
    parameter int                            LOCKOUT_CYCLES = 100000000
) (
    input logic                 clk,
    input logic                 rst,
    param_combo_lock_if.slave   bus
);
    localparam int CW = DIGITS * DIGIT_W;
    localparam int EW = $clog2(DIGITS + 1);
    localparam int FW = $clog2(MAX_TRIES + 1);
    localparam int TW = $clog2(LOCKOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        LOCKED   = 2'b00,
        UNLOCKED = 2'b01,
        ERROR    = 2'b10,
        LOCKOUT  = 2'b11
    } lockStateT;

    lockStateT       lockState;
    logic [CW-1:0]   code;
    logic [CW-1:0]   entry;
    logic [CW-1:0]   shifted;
    logic [EW-1:0]   entryCnt;
    logic [FW-1:0]   failCnt;
    logic [TW-1:0]   timer;
    logic            codeSet;
    logic            unlocked;

    // Shift form rather than a part-select so DIGITS=1 stays legal.
    assign shifted  = (entry << DIGIT_W) | CW'(bus.digit_in);
    assign unlocked = lockState == UNLOCKED;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lockState <= LOCKED;
            code      <= RESET_CODE;
            entry     <= '0;
            entryCnt  <= '0;
            failCnt   <= '0;
            timer     <= '0;
            codeSet   <= 1'b0;
        end else begin
            codeSet <= 1'b0;
            if (lockState == LOCKOUT) begin
                // Timer is loaded with LOCKOUT_CYCLES-1, so leaving on the zero cycle gives an exact dwell.
                if (timer == '0) begin
                    lockState <= LOCKED;
                    failCnt   <= '0;
                end else begin
                    timer <= timer - 1'b1;
                end
            end else if (unlocked && bus.lock_req) begin
                lockState <= LOCKED;
                entry     <= '0;
                entryCnt  <= '0;
            end else if (unlocked && bus.set_code && entryCnt == EW'(DIGITS)) begin
                code     <= entry;
                codeSet  <= 1'b1;
                entry    <= '0;
                entryCnt <= '0;
            end else if (bus.clr) begin
                entry    <= '0;
                entryCnt <= '0;
                if (lockState == ERROR) lockState <= LOCKED;
            end else if (bus.digit_valid) begin
                if (unlocked) begin
                    entry <= shifted;
                    if (entryCnt != EW'(DIGITS)) entryCnt <= entryCnt + 1'b1;
                end else if (entryCnt == EW'(DIGITS - 1)) begin
                    entry    <= '0;
                    entryCnt <= '0;
                    if (shifted == code) begin
                        lockState <= UNLOCKED;
                        failCnt   <= '0;
                    end else if (failCnt == FW'(MAX_TRIES - 1)) begin
                        lockState <= LOCKOUT;
                        failCnt   <= FW'(MAX_TRIES);
                        timer     <= TW'(LOCKOUT_CYCLES - 1);
                    end else begin
                        lockState <= ERROR;
                        failCnt   <= failCnt + 1'b1;
                    end
                end else begin
                    // A non-completing digit also clears a pending ERROR indication.
                    entry     <= shifted;
                    entryCnt  <= entryCnt + 1'b1;
                    lockState <= LOCKED;
                end
            end
        end
    end

    assign bus.state     = lockState;
    assign bus.entry     = entry;
    assign bus.entry_cnt = entryCnt;
    assign bus.fail_cnt  = failCnt;
    assign bus.code_set  = codeSet;
endmodule

// File: tb/tb_param_combo_lock.sv
// tb_param_combo_lock: table-driven check of the combination lock with hand sequences for lockout and reset.
module tb_param_combo_lock;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    param_combo_lock_if #(.DIGITS(4), .DIGIT_W(4), .MAX_TRIES(3)) bus ();

    param_combo_lock #(
        .DIGITS(4), .DIGIT_W(4), .RESET_CODE(16'h1234), .MAX_TRIES(3), .LOCKOUT_CYCLES(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        dv;
        logic [3:0]  d;
        logic        clr;
        logic        lk;
        logic        sc;
        logic [1:0]  st;
        logic [15:0] en;
        logic [2:0]  cnt;
        logic [1:0]  fc;
        logic        cs;
    } vecT;

    vecT vecs[$];

    function automatic void add(input string name, input logic dv, input logic [3:0] d, input logic clr,
                                input logic lk, input logic sc, input logic [1:0] st, input logic [15:0] en,
                                input logic [2:0] cnt, input logic [1:0] fc, input logic cs);
        vecT v;
        v.name = name; v.dv = dv; v.d = d; v.clr = clr; v.lk = lk; v.sc = sc;
        v.st = st; v.en = en; v.cnt = cnt; v.fc = fc; v.cs = cs;
        vecs.push_back(v);
    endfunction

    function automatic void dg(input string name, input logic [3:0] d, input logic [1:0] st,
                               input logic [15:0] en, input logic [2:0] cnt, input logic [1:0] fc);
        add(name, 1'b1, d, 1'b0, 1'b0, 1'b0, st, en, cnt, fc, 1'b0);
    endfunction

    function automatic void ctl(input string name, input logic clr, input logic lk, input logic sc,
                                input logic [1:0] st, input logic [15:0] en, input logic [2:0] cnt,
                                input logic [1:0] fc, input logic cs);
        add(name, 1'b0, 4'h0, clr, lk, sc, st, en, cnt, fc, cs);
    endfunction

    // Three all-zero entries against a non-zero code, starting from LOCKED with fail_cnt=0.
    function automatic void addZeros();
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < 3; k++) dg("zero_digit", 4'h0, 2'd0, 16'h0, 3'(k + 1), 2'(t));
            if (t < 2) dg("zero_err", 4'h0, 2'd2, 16'h0, 3'd0, 2'(t + 1));
            else       dg("zero_lockout", 4'h0, 2'd3, 16'h0, 3'd0, 2'd3);
        end
    endfunction

    task automatic check(input string name, input logic [1:0] st, input logic [15:0] en,
                         input logic [2:0] cnt, input logic [1:0] fc, input logic cs);
        vectors++;
        if (bus.state !== st || bus.entry !== en || bus.entry_cnt !== cnt ||
            bus.fail_cnt !== fc || bus.code_set !== cs) begin
            miscompares++;
            $display("FAIL %s: got state=%b entry=%h cnt=%0d fail=%0d code_set=%b, want state=%b entry=%h cnt=%0d fail=%0d code_set=%b",
                     name, bus.state, bus.entry, bus.entry_cnt, bus.fail_cnt, bus.code_set, st, en, cnt, fc, cs);
        end
    endtask

    task automatic apply(input vecT v);
        @(negedge clk);
        bus.digit_in    = v.d;
        bus.digit_valid = v.dv;
        bus.clr         = v.clr;
        bus.lock_req    = v.lk;
        bus.set_code    = v.sc;
        @(posedge clk);
        #1;
        bus.digit_valid = 1'b0;
        bus.clr         = 1'b0;
        bus.lock_req    = 1'b0;
        bus.set_code    = 1'b0;
        check(v.name, v.st, v.en, v.cnt, v.fc, v.cs);
    endtask

    task automatic runTable();
        foreach (vecs[i]) apply(vecs[i]);
        vecs.delete();
    endtask

    initial begin
        vecT v;
        bus.digit_in = '0; bus.digit_valid = 1'b0; bus.clr = 1'b0; bus.lock_req = 1'b0; bus.set_code = 1'b0;
        #12;
        check("reset", 2'd0, 16'h0, 3'd0, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Unlock, two failures, recovery, then drive into lockout.
        dg("ok_1", 4'h1, 2'd0, 16'h0001, 3'd1, 2'd0);
        dg("ok_2", 4'h2, 2'd0, 16'h0012, 3'd2, 2'd0);
        dg("ok_3", 4'h3, 2'd0, 16'h0123, 3'd3, 2'd0);
        dg("ok_4", 4'h4, 2'd1, 16'h0000, 3'd0, 2'd0);
        ctl("relock", 1'b0, 1'b1, 1'b0, 2'd0, 16'h0, 3'd0, 2'd0, 1'b0);
        dg("bad1_1", 4'h1, 2'd0, 16'h0001, 3'd1, 2'd0);
        dg("bad1_2", 4'h2, 2'd0, 16'h0012, 3'd2, 2'd0);
        dg("bad1_3", 4'h3, 2'd0, 16'h0123, 3'd3, 2'd0);
        dg("bad1_4", 4'h5, 2'd2, 16'h0000, 3'd0, 2'd1);
        dg("bad2_1", 4'h1, 2'd0, 16'h0001, 3'd1, 2'd1);
        dg("bad2_2", 4'h2, 2'd0, 16'h0012, 3'd2, 2'd1);
        dg("bad2_3", 4'h3, 2'd0, 16'h0123, 3'd3, 2'd1);
        dg("bad2_4", 4'h5, 2'd2, 16'h0000, 3'd0, 2'd2);
        dg("fix_1", 4'h1, 2'd0, 16'h0001, 3'd1, 2'd2);
        dg("fix_2", 4'h2, 2'd0, 16'h0012, 3'd2, 2'd2);
        dg("fix_3", 4'h3, 2'd0, 16'h0123, 3'd3, 2'd2);
        dg("fix_4", 4'h4, 2'd1, 16'h0000, 3'd0, 2'd0);
        ctl("relock2", 1'b0, 1'b1, 1'b0, 2'd0, 16'h0, 3'd0, 2'd0, 1'b0);
        addZeros();
        runTable();

        // Lockout: 19 more cycles in LOCKOUT with every control pulsed, then LOCKED on the 20th.
        for (int i = 0; i < 19; i++) begin
            v.name = "lockout_hold"; v.dv = 1'b1; v.d = 4'h7;
            v.clr = (i % 4) == 1; v.lk = (i % 4) == 2; v.sc = (i % 4) == 3;
            v.st = 2'd3; v.en = 16'h0; v.cnt = 3'd0; v.fc = 2'd3; v.cs = 1'b0;
            apply(v);
        end
        v.name = "lockout_exit"; v.dv = 1'b0; v.clr = 1'b0; v.lk = 1'b0; v.sc = 1'b0;
        v.st = 2'd0; v.fc = 2'd0;
        apply(v);

        // Reprogram to ABCD, verify old code now fails and new code works.
        dg("post_1", 4'h1, 2'd0, 16'h0001, 3'd1, 2'd0);
        dg("post_2", 4'h2, 2'd0, 16'h0012, 3'd2, 2'd0);
        dg("post_3", 4'h3, 2'd0, 16'h0123, 3'd3, 2'd0);
        dg("post_4", 4'h4, 2'd1, 16'h0000, 3'd0, 2'd0);
        dg("new_a", 4'hA, 2'd1, 16'h000A, 3'd1, 2'd0);
        dg("new_b", 4'hB, 2'd1, 16'h00AB, 3'd2, 2'd0);
        dg("new_c", 4'hC, 2'd1, 16'h0ABC, 3'd3, 2'd0);
        dg("new_d", 4'hD, 2'd1, 16'hABCD, 3'd4, 2'd0);
        ctl("set_code", 1'b0, 1'b0, 1'b1, 2'd1, 16'h0, 3'd0, 2'd0, 1'b1);
        ctl("code_set_off", 1'b0, 1'b0, 1'b0, 2'd1, 16'h0, 3'd0, 2'd0, 1'b0);
        ctl("lock3", 1'b0, 1'b1, 1'b0, 2'd0, 16'h0, 3'd0, 2'd0, 1'b0);
        dg("old_1", 4'h1, 2'd0, 16'h0001, 3'd1, 2'd0);
        dg("old_2", 4'h2, 2'd0, 16'h0012, 3'd2, 2'd0);
        dg("old_3", 4'h3, 2'd0, 16'h0123, 3'd3, 2'd0);
        dg("old_4", 4'h4, 2'd2, 16'h0000, 3'd0, 2'd1);
        dg("abcd_a", 4'hA, 2'd0, 16'h000A, 3'd1, 2'd1);
        dg("abcd_b", 4'hB, 2'd0, 16'h00AB, 3'd2, 2'd1);
        dg("abcd_c", 4'hC, 2'd0, 16'h0ABC, 3'd3, 2'd1);
        dg("abcd_d", 4'hD, 2'd1, 16'h0000, 3'd0, 2'd0);
        // Saturation while unlocked, short set_code, priority cases.
        dg("sat_1", 4'h1, 2'd1, 16'h0001, 3'd1, 2'd0);
        dg("sat_2", 4'h2, 2'd1, 16'h0012, 3'd2, 2'd0);
        dg("sat_3", 4'h3, 2'd1, 16'h0123, 3'd3, 2'd0);
        dg("sat_4", 4'h4, 2'd1, 16'h1234, 3'd4, 2'd0);
        dg("sat_5", 4'h5, 2'd1, 16'h2345, 3'd4, 2'd0);
        ctl("clr_unlocked", 1'b1, 1'b0, 1'b0, 2'd1, 16'h0, 3'd0, 2'd0, 1'b0);
        dg("short_1", 4'h1, 2'd1, 16'h0001, 3'd1, 2'd0);
        dg("short_2", 4'h2, 2'd1, 16'h0012, 3'd2, 2'd0);
        ctl("short_set", 1'b0, 1'b0, 1'b1, 2'd1, 16'h0012, 3'd2, 2'd0, 1'b0);
        add("clr_beats_digit", 1'b1, 4'h9, 1'b1, 1'b0, 1'b0, 2'd1, 16'h0, 3'd0, 2'd0, 1'b0);
        dg("pri_7", 4'h7, 2'd1, 16'h0007, 3'd1, 2'd0);
        add("lock_beats_digit", 1'b1, 4'h8, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0, 3'd0, 2'd0, 1'b0);
        dg("keep_a", 4'hA, 2'd0, 16'h000A, 3'd1, 2'd0);
        dg("keep_b", 4'hB, 2'd0, 16'h00AB, 3'd2, 2'd0);
        dg("keep_c", 4'hC, 2'd0, 16'h0ABC, 3'd3, 2'd0);
        dg("keep_d", 4'hD, 2'd1, 16'h0000, 3'd0, 2'd0);
        ctl("lock4", 1'b0, 1'b1, 1'b0, 2'd0, 16'h0, 3'd0, 2'd0, 1'b0);
        dg("err_1", 4'h1, 2'd0, 16'h0001, 3'd1, 2'd0);
        dg("err_2", 4'h1, 2'd0, 16'h0011, 3'd2, 2'd0);
        dg("err_3", 4'h1, 2'd0, 16'h0111, 3'd3, 2'd0);
        dg("err_4", 4'h1, 2'd2, 16'h0000, 3'd0, 2'd1);
        ctl("clr_error", 1'b1, 1'b0, 1'b0, 2'd0, 16'h0, 3'd0, 2'd1, 1'b0);
        dg("mid_1", 4'h1, 2'd0, 16'h0001, 3'd1, 2'd1);
        dg("mid_2", 4'h2, 2'd0, 16'h0012, 3'd2, 2'd1);
        runTable();

        // Asynchronous reset mid-entry, checked before any clock edge.
        #2 rst = 1'b0;
        #1 check("rst_mid_entry", 2'd0, 16'h0, 3'd0, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Asynchronous reset mid-lockout, then the reset code must unlock again.
        addZeros();
        dg("lk_hold_1", 4'h6, 2'd3, 16'h0, 3'd0, 2'd3);
        dg("lk_hold_2", 4'h6, 2'd3, 16'h0, 3'd0, 2'd3);
        runTable();
        #2 rst = 1'b0;
        #1 check("rst_mid_lockout", 2'd0, 16'h0, 3'd0, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        dg("rc_1", 4'h1, 2'd0, 16'h0001, 3'd1, 2'd0);
        dg("rc_2", 4'h2, 2'd0, 16'h0012, 3'd2, 2'd0);
        dg("rc_3", 4'h3, 2'd0, 16'h0123, 3'd3, 2'd0);
        dg("rc_4", 4'h4, 2'd1, 16'h0000, 3'd0, 2'd0);
        runTable();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
